// File: rtl/exgcd_pkg.sv
// Shared types and constants for the extended-GCD request scheduler.
package exgcd_pkg;

  localparam int EXGCD_W = 8;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ZERO    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_NOINV   = 2'b11;

endpackage

// File: rtl/exgcd_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int IW = $clog2(NREQ);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int step);
    return IW'((int'(base) + step) % NREQ);
  endfunction

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[wrap_idx(last_grant, k)]) begin
        grant                           = '0;
        grant[wrap_idx(last_grant, k)]  = 1'b1;
        grant_idx                       = wrap_idx(last_grant, k);
      end
    end
  end

endmodule

// File: rtl/exgcd_sched.sv
// Round-robin scheduler/sequencer for the shared extended-GCD engine.
// Optional watchdog abort is built when EXGCD_SCHED_TIMEOUT_EN is defined.
module exgcd_sched
  import exgcd_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [EXGCD_W*NREQ-1:0] req_a,
  input  logic [EXGCD_W*NREQ-1:0] req_b,
  output logic                    eng_start,
  output logic [EXGCD_W-1:0]      eng_a,
  output logic [EXGCD_W-1:0]      eng_b,
  output logic                    eng_abort,
  input  logic                    eng_done,
  input  logic [EXGCD_W-1:0]      eng_gcd,
  input  logic [EXGCD_W-1:0]      eng_inv,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2:0]              rsp_id,
  output logic [EXGCD_W-1:0]      rsp_gcd,
  output logic [EXGCD_W-1:0]      rsp_inv,
  output logic [1:0]              rsp_err
);

  localparam int IW = $clog2(NREQ);

  state_t             state, next_state;
  logic               arb_en;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      grant_idx;
  logic [NREQ-1:0]    grant;
  logic               accept;
  logic               zero_op;
  logic               timeout_hit;
  logic [EXGCD_W-1:0] sel_a, sel_b;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign sel_a   = req_a[EXGCD_W*int'(grant_idx) +: EXGCD_W];
  assign sel_b   = req_b[EXGCD_W*int'(grant_idx) +: EXGCD_W];
  assign zero_op = (sel_a == '0) || (sel_b == '0);
  // arb_en keeps req_ready low while in reset and on the first cycle out of it.
  assign accept  = (state == ARB) && arb_en && (|req_valid);

`ifdef EXGCD_SCHED_TIMEOUT_EN
  logic [7:0] wdog;

  // eng_done on the terminal cycle takes priority over the abort.
  assign timeout_hit = (state == WAIT) && !eng_done && (wdog == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               wdog <= '0;
    else if (state == ISSUE)  wdog <= '0;
    else if (state == WAIT)   wdog <= wdog + 8'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ARB:     if (accept) next_state = zero_op ? RESP : ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (eng_done || timeout_hit) next_state = RESP;
      RESP:    if (rsp_ready) next_state = ARB;
      default: next_state = ARB;
    endcase
  end

  always_comb begin
    req_ready = '0;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      ARB:     if (arb_en) req_ready = grant;
      ISSUE:   eng_start = 1'b1;
      WAIT:    eng_abort = timeout_hit;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_en     <= 1'b0;
      last_grant <= IW'(NREQ - 1);
      eng_a      <= '0;
      eng_b      <= '0;
      rsp_id     <= '0;
      rsp_gcd    <= '0;
      rsp_inv    <= '0;
      rsp_err    <= ERR_OK;
    end else begin
      arb_en <= (next_state == ARB);
      if (accept) begin
        last_grant <= grant_idx;
        eng_a      <= sel_a;
        eng_b      <= sel_b;
        rsp_id     <= 3'(grant_idx);
        if (zero_op) begin
          rsp_gcd <= '0;
          rsp_inv <= '0;
          rsp_err <= ERR_ZERO;
        end
      end
      if (state == WAIT && eng_done) begin
        rsp_gcd <= eng_gcd;
        rsp_inv <= eng_inv;
        rsp_err <= (eng_gcd == EXGCD_W'(1)) ? ERR_OK : ERR_NOINV;
      end else if (timeout_hit) begin
        rsp_gcd <= '0;
        rsp_inv <= '0;
        rsp_err <= ERR_TIMEOUT;
      end
    end
  end

endmodule
